sad_bank_writer: RTL
====================

# sad_bank_writer

Loads one reference/search frame, delivered as a raster-order pixel stream, into the 16 MultiMem data banks that feed the Sadder array. Column `c` of every row lands in bank `c mod 16` at word address `row*(COLS/16) + c/16`, so the bank readers can fetch 16 horizontally adjacent pixels in one cycle. The block is the write-side counterpart of the memory read state machine. It sits between the frame input stream and the DM1..DM16 write ports.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits.
- COLS, 64, pixels per row; a power of two and a multiple of 16.
- ROWS, 64, rows per frame; a power of two.
- ADDR_W, 8, bank word-address width; must satisfy 2^ADDR_W ≥ ROWS*COLS/16.

Ports:
- Clk, in, 1, single clock; all logic on rising edge.
- Reset, in, 1, synchronous, active-high reset.
- Start, in, 1, begin loading a frame; sampled only in IDLE.
- InValid, in, 1, InData holds a valid pixel.
- InData, in, DATA_W, pixel value in raster order (row 0 col 0 first).
- InReady, out, 1, block accepts a pixel this cycle.
- Address, out, ADDR_W, shared word address for all banks.
- WriteData, out, DATA_W, shared write data for all banks.
- MemWrite, out, 16, one-hot bank write enable; bit k drives DM(k+1).
- Busy, out, 1, high in every state other than IDLE.
- Done, out, 1, one-cycle pulse when the frame has been fully written.
- FrameCount, out, 8, number of completed frames since reset; wraps 255→0.

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - InReady=0, MemWrite=0.
  - Start=1 → LOAD; clear col and row counters.
- LOAD:
  - InReady=1.
  - A pixel is accepted when InValid && InReady.
  - On accept, the next cycle presents:
    - Address = row*(COLS/16) + col[log2(COLS)-1:4]
    - WriteData = InData
    - MemWrite = 1 << col[3:0]
  - With no accept, MemWrite=0 next cycle; Address and WriteData hold their last value.
- Counters:
  - col increments on each accept; wraps COLS-1→0, and row increments on that wrap.
  - Accepting the pixel at row=ROWS-1, col=COLS-1 → FLUSH.
- FLUSH:
  - InReady=0; the last write is presented.
  - Unconditional → DONE.
- DONE:
  - InReady=0, MemWrite=0, Done=1.
  - FrameCount increments.
  - Unconditional → IDLE.
- Start outside IDLE is ignored; it is not queued.
- InData is ignored whenever InReady=0.
- At most one MemWrite bit is high in any cycle.
- Every bank receives exactly ROWS*COLS/16 writes per frame, at addresses 0..ROWS*COLS/16-1 in ascending order.
- Reset mid-frame:
  - The next cycle is IDLE with all outputs at reset values.
  - The partially loaded frame is abandoned; bank contents are not cleared.
  - FrameCount is not incremented.

## Timing
- Reset values: InReady=0, Address=0, WriteData=0, MemWrite=0, Busy=0, Done=0, FrameCount=0; state IDLE.
- Start at cycle t → LOAD and InReady=1 at t+1.
- Accept at cycle t → MemWrite/Address/WriteData at t+1. MultiMem commits the write on the edge ending t+1.
- Throughput: one pixel per cycle while InValid stays high. A full frame takes ROWS*COLS cycles in LOAD.
- Last accept at cycle t:
  - FLUSH with the last write at t+1.
  - Done=1 and FrameCount+1 visible at t+2.
  - IDLE at t+3; Start is accepted at t+3 at the earliest.
- Busy=1 from the cycle after Start through the Done cycle inclusive.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset check: hold Reset 3 cycles with random Start and InValid → all outputs 0, InReady=0, no MemWrite bit ever high.
- Full frame at ROWS=2, COLS=32, InValid held high, InData = 0..63:
  - Pixel 17 → MemWrite=0x0002, Address=1, WriteData=17.
  - Pixel 47 → MemWrite=0x8000, Address=2, WriteData=47.
  - Done pulses exactly 1 cycle, 2 cycles after pixel 63; FrameCount=1.
- Backpressure: InValid toggled pseudo-randomly over a full frame → no write during InValid=0 gaps; final bank contents identical to the no-gap run; write count per bank = 4.
- Start while busy: pulse Start during LOAD and during DONE → no effect. A second frame begins only on a Start in IDLE.
- Reset at pixel 20:
  - IDLE next cycle, Busy=0, FrameCount unchanged.
  - A new Start, then 64 pixels → first write is Address=0, MemWrite=0x0001.
- FrameCount wrap: 256 back-to-back frames with Start asserted each IDLE cycle → FrameCount reads 0 after frame 256, and Done has pulsed 256 times.

Source files
------------

// File: rtl/sad_bank_writer.sv
// Writes one raster-order frame into the 16 MultiMem banks feeding the Sadder array.
// Column c of each row goes to bank c mod 16 at word row*(COLS/16) + c/16.
module sad_bank_writer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COLS   = 64,
  parameter int unsigned ROWS   = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic [15:0]       MemWrite,
  output logic              Busy,
  output logic              Done,
  output logic [7:0]        FrameCount
);

  localparam int unsigned NBANK = 16;
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned WPR   = COLS / NBANK;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t            state, state_d;
  logic [COL_W-1:0]  col, col_d;
  logic [ROW_W-1:0]  row, row_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [NBANK-1:0]  we_d;
  logic [7:0]        fcount_d;
  logic              accept;
  logic              last_col;
  logic              last_row;

  // InReady is high exactly while in LOAD, so it doubles as the accept qualifier.
  always_comb begin
    accept   = InValid && InReady;
    last_col = (col == COL_W'(COLS - 1));
    last_row = (row == ROW_W'(ROWS - 1));
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state plus next values for every registered output and counter.
  always_comb begin
    state_d  = state;
    col_d    = col;
    row_d    = row;
    addr_d   = Address;
    wdata_d  = WriteData;
    we_d     = '0;
    fcount_d = FrameCount;

    case (state)
      IDLE: begin
        if (Start) begin
          state_d = LOAD;
          col_d   = '0;
          row_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          addr_d  = ADDR_W'(row) * ADDR_W'(WPR) + ADDR_W'(col >> 4);
          wdata_d = InData;
          we_d    = NBANK'(1) << col[3:0];
          if (last_col) begin
            col_d = '0;
            row_d = row + ROW_W'(1);
            if (last_row) state_d = FLUSH;
          end else begin
            col_d = col + COL_W'(1);
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) fcount_d = FrameCount + 8'd1;
  end

  // Output and counter registers, all loaded from the next-state logic.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      col        <= '0;
      row        <= '0;
      InReady    <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
      MemWrite   <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      FrameCount <= '0;
    end else begin
      col        <= col_d;
      row        <= row_d;
      InReady    <= (state_d == LOAD);
      Address    <= addr_d;
      WriteData  <= wdata_d;
      MemWrite   <= we_d;
      Busy       <= (state_d != IDLE);
      Done       <= (state_d == DONE);
      FrameCount <= fcount_d;
    end
  end

endmodule
